// File: rtl/uart_echo_tester_if.sv
// UART-side strobes between the echo tester (master) and the uart_top it drives (slave).
interface uart_echo_tester_if;
  logic       o_tx_dv;
  logic [7:0] o_tx_byte;
  logic       i_tx_active;
  logic       i_tx_done;
  logic       i_rx_dv;
  logic [7:0] i_rx_byte;

  modport master (
    output o_tx_dv, o_tx_byte,
    input  i_tx_active, i_tx_done, i_rx_dv, i_rx_byte
  );

  modport slave (
    input  o_tx_dv, o_tx_byte,
    output i_tx_active, i_tx_done, i_rx_dv, i_rx_byte
  );
endinterface

// File: rtl/uart_echo_tester.sv
// Initiator for the header-synchronised UART echo responder: sends the sync
// header once per reset, then a counting payload, and checks every echo.
//
// state         | meaning
// IDLE          | waiting for an accepted start
// SEND_HDR      | strobing the sync header
// WAIT_HDR_DONE | header on the line; no echo expected
// SEND_DATA     | waiting for an idle transmitter, then strobing payload[idx]
// WAIT_ECHO     | waiting for the echo of payload[idx] or a timeout
// FINISH        | publishing pass/done for the run
module uart_echo_tester #(
  parameter int unsigned CLK_FREQ_HZ    = 25_000_000,
  parameter int unsigned BAUD_RATE      = 9600,
  parameter int unsigned PAYLOAD_LEN    = 8,
  parameter logic [7:0]  HEADER_BYTE    = 8'hAA,
  parameter logic [7:0]  SEED           = 8'h41,
  parameter int unsigned TIMEOUT_CYCLES = 40 * CLK_FREQ_HZ / BAUD_RATE
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  uart_echo_tester_if.master  uart,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_pass,
  output logic [7:0]          o_err_count,
  output logic [7:0]          o_rx_count
);

  typedef enum logic [2:0] {
    IDLE, SEND_HDR, WAIT_HDR_DONE, SEND_DATA, WAIT_ECHO, FINISH
  } state_t;

  localparam logic [7:0]  LAST_IDX = 8'(PAYLOAD_LEN - 1);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nxt;
  logic        hdr_sent, hdr_sent_nxt;
  logic [7:0]  idx, idx_nxt;
  logic [7:0]  expected, expected_nxt;
  logic [31:0] tmo_cnt, tmo_cnt_nxt;
  logic        tx_dv, tx_dv_nxt;
  logic [7:0]  tx_byte, tx_byte_nxt;
  logic        busy_nxt, done_nxt, pass_nxt;
  logic [7:0]  err_nxt, rx_nxt, err_inc;
  logic        advance;

  assign uart.o_tx_dv   = tx_dv;
  assign uart.o_tx_byte = tx_byte;
  assign err_inc = (o_err_count == 8'hFF) ? 8'hFF : o_err_count + 8'd1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      hdr_sent    <= 1'b0;
      idx         <= 8'd0;
      expected    <= 8'd0;
      tmo_cnt     <= 32'd0;
      tx_dv       <= 1'b0;
      tx_byte     <= 8'h00;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_pass      <= 1'b0;
      o_err_count <= 8'd0;
      o_rx_count  <= 8'd0;
    end else begin
      state       <= state_nxt;
      hdr_sent    <= hdr_sent_nxt;
      idx         <= idx_nxt;
      expected    <= expected_nxt;
      tmo_cnt     <= tmo_cnt_nxt;
      tx_dv       <= tx_dv_nxt;
      tx_byte     <= tx_byte_nxt;
      o_busy      <= busy_nxt;
      o_done      <= done_nxt;
      o_pass      <= pass_nxt;
      o_err_count <= err_nxt;
      o_rx_count  <= rx_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    hdr_sent_nxt = hdr_sent;
    idx_nxt      = idx;
    expected_nxt = expected;
    tmo_cnt_nxt  = tmo_cnt;
    tx_dv_nxt    = 1'b0;
    tx_byte_nxt  = tx_byte;
    done_nxt     = 1'b0;
    pass_nxt     = o_pass;
    err_nxt      = o_err_count;
    rx_nxt       = o_rx_count;
    advance      = 1'b0;

    case (state)
      IDLE: begin
        // o_done high means FINISH just retired; a start in that cycle is dropped
        if (i_start && !uart.i_tx_active && !o_done) begin
          err_nxt   = 8'd0;
          rx_nxt    = 8'd0;
          pass_nxt  = 1'b0;
          idx_nxt   = 8'd0;
          state_nxt = hdr_sent ? SEND_DATA : SEND_HDR;
        end
      end
      SEND_HDR: begin
        tx_dv_nxt    = 1'b1;
        tx_byte_nxt  = HEADER_BYTE;
        hdr_sent_nxt = 1'b1;
        state_nxt    = WAIT_HDR_DONE;
      end
      WAIT_HDR_DONE: begin
        if (uart.i_tx_done) state_nxt = SEND_DATA;
      end
      SEND_DATA: begin
        if (!uart.i_tx_active) begin
          tx_dv_nxt    = 1'b1;
          tx_byte_nxt  = SEED + idx;
          expected_nxt = SEED + idx;
          tmo_cnt_nxt  = 32'd0;
          state_nxt    = WAIT_ECHO;
        end
      end
      WAIT_ECHO: begin
        // an echo landing on the timeout cycle wins over the timeout
        if (uart.i_rx_dv) begin
          rx_nxt  = o_rx_count + 8'd1;
          if (uart.i_rx_byte != expected) err_nxt = err_inc;
          advance = 1'b1;
        end else if (tmo_cnt == TMO_LAST) begin
          err_nxt = err_inc;
          advance = 1'b1;
        end else begin
          tmo_cnt_nxt = tmo_cnt + 32'd1;
        end
        if (advance) begin
          if (idx == LAST_IDX) begin
            state_nxt = FINISH;
          end else begin
            idx_nxt   = idx + 8'd1;
            state_nxt = SEND_DATA;
          end
        end
      end
      FINISH: begin
        done_nxt  = 1'b1;
        pass_nxt  = (o_err_count == 8'd0);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_uart_echo_tester.sv
// Bench for uart_echo_tester: two instances looped through a behavioural UART
// plus echo responder that swallows the first header after reset.
module tb_uart_echo_tester;
  localparam int         TMO   = 120;
  localparam int         FRAME = 10;
  localparam logic [7:0] SEED0 = 8'h41;
  localparam logic [7:0] SEED1 = 8'hFE;
  localparam int         LEN0  = 8;
  localparam int         LEN1  = 4;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  logic       rst_n;
  logic       start [2];
  logic       busy [2], done [2], pass [2];
  logic [7:0] errc [2], rxc [2];

  logic       tx_dv_s [2];
  logic [7:0] tx_byte_s [2];
  logic       tx_active_m [2], tx_done_m [2], rx_dv_m [2];
  logic [7:0] rx_byte_m [2];
  logic       spur_dv [2];

  int         tx_timer [2], rx_timer [2];
  logic       swallowed [2], echo_pend [2];
  logic [7:0] echo_byte [2];
  logic [7:0] fault_xor [2][256];
  logic       fault_drop [2][256];
  logic [7:0] tx_log [2][$];
  int         tx_cyc [2][$];

  logic hdr_model [2];
  int   n_cmp = 0;
  int   n_bad = 0;

  uart_echo_tester_if bus0 ();
  uart_echo_tester_if bus1 ();

  uart_echo_tester #(.PAYLOAD_LEN(LEN0), .SEED(SEED0), .TIMEOUT_CYCLES(TMO)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start[0]), .uart(bus0),
    .o_busy(busy[0]), .o_done(done[0]), .o_pass(pass[0]),
    .o_err_count(errc[0]), .o_rx_count(rxc[0]));

  uart_echo_tester #(.PAYLOAD_LEN(LEN1), .SEED(SEED1), .TIMEOUT_CYCLES(TMO)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start[1]), .uart(bus1),
    .o_busy(busy[1]), .o_done(done[1]), .o_pass(pass[1]),
    .o_err_count(errc[1]), .o_rx_count(rxc[1]));

  assign tx_dv_s[0]       = bus0.o_tx_dv;
  assign tx_byte_s[0]     = bus0.o_tx_byte;
  assign bus0.i_tx_active = tx_active_m[0];
  assign bus0.i_tx_done   = tx_done_m[0];
  assign bus0.i_rx_dv     = rx_dv_m[0] | spur_dv[0];
  assign bus0.i_rx_byte   = spur_dv[0] ? 8'h55 : rx_byte_m[0];
  assign tx_dv_s[1]       = bus1.o_tx_dv;
  assign tx_byte_s[1]     = bus1.o_tx_byte;
  assign bus1.i_tx_active = tx_active_m[1];
  assign bus1.i_tx_done   = tx_done_m[1];
  assign bus1.i_rx_dv     = rx_dv_m[1] | spur_dv[1];
  assign bus1.i_rx_byte   = spur_dv[1] ? 8'h55 : rx_byte_m[1];

  function automatic logic [7:0] seed_of(input int i);
    return (i == 0) ? SEED0 : SEED1;
  endfunction

  function automatic int len_of(input int i);
    return (i == 0) ? LEN0 : LEN1;
  endfunction

  function automatic int pidx(input int i, input logic [7:0] b);
    logic [7:0] d;
    d = b - seed_of(i);
    return int'(d);
  endfunction

  // Expected TX stream of one run: header only on the first run after reset.
  function automatic bq_t exp_seq(input int i);
    bq_t q;
    q = {};
    if (!hdr_model[i]) q.push_back(8'hAA);
    for (int k = 0; k < len_of(i); k++) q.push_back(8'(seed_of(i) + 8'(k)));
    return q;
  endfunction

  // UART line model: frame of FRAME cycles, then the echo after a random gap.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        tx_active_m[i] <= 1'b0;
        tx_done_m[i]   <= 1'b0;
        rx_dv_m[i]     <= 1'b0;
        rx_byte_m[i]   <= 8'h00;
        tx_timer[i]    <= 0;
        rx_timer[i]    <= 0;
        swallowed[i]   <= 1'b0;
        echo_pend[i]   <= 1'b0;
        echo_byte[i]   <= 8'h00;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        tx_done_m[i] <= 1'b0;
        rx_dv_m[i]   <= 1'b0;
        if (tx_dv_s[i]) begin
          tx_log[i].push_back(tx_byte_s[i]);
          tx_cyc[i].push_back(cycle);
          tx_active_m[i] <= 1'b1;
          tx_timer[i]    <= FRAME;
          if (tx_byte_s[i] == 8'hAA && !swallowed[i]) begin
            swallowed[i] <= 1'b1;
            echo_pend[i] <= 1'b0;
          end else begin
            echo_pend[i] <= !fault_drop[i][pidx(i, tx_byte_s[i])];
            echo_byte[i] <= tx_byte_s[i] ^ fault_xor[i][pidx(i, tx_byte_s[i])];
          end
        end else if (tx_timer[i] != 0) begin
          tx_timer[i] <= tx_timer[i] - 1;
          if (tx_timer[i] == 1) begin
            tx_active_m[i] <= 1'b0;
            tx_done_m[i]   <= 1'b1;
            echo_pend[i]   <= 1'b0;
            if (echo_pend[i]) rx_timer[i] <= int'($urandom_range(30, 2));
          end
        end
        if (rx_timer[i] != 0) begin
          rx_timer[i] <= rx_timer[i] - 1;
          if (rx_timer[i] == 1) begin
            rx_dv_m[i]   <= 1'b1;
            rx_byte_m[i] <= echo_byte[i];
          end
        end
      end
    end
  end

  task automatic clear_faults();
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 256; k++) begin
        fault_xor[i][k]  = 8'h00;
        fault_drop[i][k] = 1'b0;
      end
  endtask

  task automatic wait_done(input int i, output bit got);
    got = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      if (done[i]) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Starts a run and follows it to completion; returns observations only.
  task automatic do_run(input int i, output int base, output int acc, output bit got,
                        output logic busy_acc, output logic busy_at_done, output int dwidth);
    base = tx_log[i].size();
    @(negedge clk);
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
    acc      = cycle;
    busy_acc = busy[i];
    wait_done(i, got);
    busy_at_done = busy[i];
    dwidth = 0;
    while (done[i] && dwidth < 4) begin
      dwidth++;
      @(negedge clk);
    end
    hdr_model[i] = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      n_cmp += 7;
      if (busy[i] !== 1'b0) begin n_bad++; $display("FAIL reset_busy[%0d]: got %b want 0", i, busy[i]); end
      if (done[i] !== 1'b0) begin n_bad++; $display("FAIL reset_done[%0d]: got %b want 0", i, done[i]); end
      if (pass[i] !== 1'b0) begin n_bad++; $display("FAIL reset_pass[%0d]: got %b want 0", i, pass[i]); end
      if (errc[i] !== 8'd0) begin n_bad++; $display("FAIL reset_err[%0d]: got %0d want 0", i, errc[i]); end
      if (rxc[i] !== 8'd0) begin n_bad++; $display("FAIL reset_rx[%0d]: got %0d want 0", i, rxc[i]); end
      if (tx_dv_s[i] !== 1'b0) begin n_bad++; $display("FAIL reset_tx_dv[%0d]: got %b want 0", i, tx_dv_s[i]); end
      if (tx_byte_s[i] !== 8'h00) begin n_bad++; $display("FAIL reset_tx_byte[%0d]: got %h want 00", i, tx_byte_s[i]); end
    end
    hdr_model[0] = 1'b0;
    hdr_model[1] = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Clean run on instance i: stream, handshake timing and result flags.
  task automatic test_clean_run(input int i, input string nm);
    int base, acc, dw;
    bit got;
    logic ba, bd;
    bq_t exp;
    clear_faults();
    exp = exp_seq(i);
    do_run(i, base, acc, got, ba, bd, dw);
    n_cmp += 9;
    if (!got) begin n_bad++; $display("FAIL %s_done_seen: got none want pulse", nm); end
    if (ba !== 1'b1) begin n_bad++; $display("FAIL %s_busy_after_start: got %b want 1", nm, ba); end
    if (dw != 1) begin n_bad++; $display("FAIL %s_done_width: got %0d want 1", nm, dw); end
    if (bd !== 1'b0) begin n_bad++; $display("FAIL %s_busy_at_done: got %b want 0", nm, bd); end
    if (pass[i] !== 1'b1) begin n_bad++; $display("FAIL %s_pass: got %b want 1", nm, pass[i]); end
    if (errc[i] !== 8'd0) begin n_bad++; $display("FAIL %s_err: got %0d want 0", nm, errc[i]); end
    if (rxc[i] !== 8'(len_of(i))) begin n_bad++; $display("FAIL %s_rx: got %0d want %0d", nm, rxc[i], len_of(i)); end
    if (tx_log[i].size() - base != exp.size()) begin
      n_bad++; $display("FAIL %s_tx_len: got %0d want %0d", nm, tx_log[i].size() - base, exp.size());
    end
    if (tx_log[i].size() <= base || tx_cyc[i][base] - acc != 1) begin
      n_bad++; $display("FAIL %s_first_tx_latency: got %0d want 1", nm,
                        (tx_log[i].size() > base) ? tx_cyc[i][base] - acc : -1);
    end
    for (int k = 0; k < exp.size() && base + k < tx_log[i].size(); k++) begin
      n_cmp++;
      if (tx_log[i][base + k] !== exp[k]) begin
        n_bad++; $display("FAIL %s_tx_byte[%0d]: got %h want %h", nm, k, tx_log[i][base + k], exp[k]);
      end
    end
  endtask

  task automatic test_corrupt();
    int base, acc, dw;
    bit got;
    logic ba, bd;
    clear_faults();
    fault_xor[0][2] = 8'h01;
    do_run(0, base, acc, got, ba, bd, dw);
    n_cmp += 4;
    if (!got) begin n_bad++; $display("FAIL corrupt_done_seen: got none want pulse"); end
    if (errc[0] !== 8'd1) begin n_bad++; $display("FAIL corrupt_err: got %0d want 1", errc[0]); end
    if (rxc[0] !== 8'd8) begin n_bad++; $display("FAIL corrupt_rx: got %0d want 8", rxc[0]); end
    if (pass[0] !== 1'b0) begin n_bad++; $display("FAIL corrupt_pass: got %b want 0", pass[0]); end
  endtask

  task automatic test_drop();
    int base, acc, dw, gap;
    bit got;
    logic ba, bd;
    clear_faults();
    fault_drop[0][4] = 1'b1;
    do_run(0, base, acc, got, ba, bd, dw);
    gap = (tx_cyc[0].size() >= base + 6) ? tx_cyc[0][base + 5] - tx_cyc[0][base + 4] : -1;
    n_cmp += 6;
    if (!got) begin n_bad++; $display("FAIL drop_done_seen: got none want pulse"); end
    if (errc[0] !== 8'd1) begin n_bad++; $display("FAIL drop_err: got %0d want 1", errc[0]); end
    if (rxc[0] !== 8'd7) begin n_bad++; $display("FAIL drop_rx: got %0d want 7", rxc[0]); end
    if (pass[0] !== 1'b0) begin n_bad++; $display("FAIL drop_pass: got %b want 0", pass[0]); end
    if (gap != TMO + 1) begin n_bad++; $display("FAIL drop_timeout_gap: got %0d want %0d", gap, TMO + 1); end
    if (tx_log[0].size() - base != LEN0) begin
      n_bad++; $display("FAIL drop_tx_len: got %0d want %0d", tx_log[0].size() - base, LEN0);
    end
  endtask

  task automatic test_random();
    int base, acc, dw, e_err, e_rx, r;
    bit got;
    logic ba, bd;
    for (int it = 0; it < 6; it++) begin
      clear_faults();
      e_err = 0;
      e_rx  = LEN0;
      for (int k = 0; k < LEN0; k++) begin
        r = int'($urandom_range(7, 0));
        if (r == 0) begin
          fault_drop[0][k] = 1'b1;
          e_err++;
          e_rx--;
        end else if (r == 1) begin
          fault_xor[0][k] = 8'($urandom_range(255, 1));
          e_err++;
        end
      end
      do_run(0, base, acc, got, ba, bd, dw);
      n_cmp += 4;
      if (!got) begin n_bad++; $display("FAIL rand%0d_done_seen: got none want pulse", it); end
      if (errc[0] !== 8'(e_err)) begin n_bad++; $display("FAIL rand%0d_err: got %0d want %0d", it, errc[0], e_err); end
      if (rxc[0] !== 8'(e_rx)) begin n_bad++; $display("FAIL rand%0d_rx: got %0d want %0d", it, rxc[0], e_rx); end
      if (pass[0] !== (e_err == 0)) begin n_bad++; $display("FAIL rand%0d_pass: got %b want %b", it, pass[0], e_err == 0); end
    end
  endtask

  // Start pulsed mid-run and a spurious echo in IDLE must both be ignored.
  task automatic test_ignored();
    int base, n;
    bit got;
    clear_faults();
    base = tx_log[0].size();
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    for (n = 0; n < 2000 && tx_log[0].size() < base + 3; n++) @(negedge clk);
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    wait_done(0, got);
    repeat (2) @(negedge clk);
    n_cmp += 4;
    if (!got) begin n_bad++; $display("FAIL midstart_done_seen: got none want pulse"); end
    if (tx_log[0].size() - base != LEN0) begin
      n_bad++; $display("FAIL midstart_tx_len: got %0d want %0d", tx_log[0].size() - base, LEN0);
    end
    if (rxc[0] !== 8'(LEN0)) begin n_bad++; $display("FAIL midstart_rx: got %0d want %0d", rxc[0], LEN0); end
    if (errc[0] !== 8'd0) begin n_bad++; $display("FAIL midstart_err: got %0d want 0", errc[0]); end
    spur_dv[0] = 1'b1;
    @(negedge clk); spur_dv[0] = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp += 4;
    if (rxc[0] !== 8'(LEN0)) begin n_bad++; $display("FAIL spur_rx: got %0d want %0d", rxc[0], LEN0); end
    if (errc[0] !== 8'd0) begin n_bad++; $display("FAIL spur_err: got %0d want 0", errc[0]); end
    if (busy[0] !== 1'b0) begin n_bad++; $display("FAIL spur_busy: got %b want 0", busy[0]); end
    if (pass[0] !== 1'b1) begin n_bad++; $display("FAIL spur_pass: got %b want 1", pass[0]); end
  endtask

  // Start held across the done cycle: dropped on it, accepted one cycle later.
  task automatic test_done_boundary();
    bit got;
    clear_faults();
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    wait_done(0, got);
    start[0] = 1'b1;
    @(negedge clk);
    n_cmp += 2;
    if (!got) begin n_bad++; $display("FAIL bound_done_seen: got none want pulse"); end
    if (busy[0] !== 1'b0) begin n_bad++; $display("FAIL bound_start_on_done: got busy %b want 0", busy[0]); end
    @(negedge clk); start[0] = 1'b0;
    n_cmp++;
    if (busy[0] !== 1'b1) begin n_bad++; $display("FAIL bound_start_after_done: got busy %b want 1", busy[0]); end
    wait_done(0, got);
    @(negedge clk);
    n_cmp += 2;
    if (!got) begin n_bad++; $display("FAIL bound_rerun_done: got none want pulse"); end
    if (pass[0] !== 1'b1) begin n_bad++; $display("FAIL bound_rerun_pass: got %b want 1", pass[0]); end
  endtask

  task automatic test_reset_mid();
    int base, n;
    clear_faults();
    base = tx_log[0].size();
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    for (n = 0; n < 2000 && tx_log[0].size() < base + 3; n++) @(negedge clk);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy[0] !== 1'b1) begin n_bad++; $display("FAIL midreset_running: got busy %b want 1", busy[0]); end
    rst_n = 1'b0;
    #1;
    n_cmp += 5;
    if (busy[0] !== 1'b0) begin n_bad++; $display("FAIL midreset_busy: got %b want 0", busy[0]); end
    if (rxc[0] !== 8'd0) begin n_bad++; $display("FAIL midreset_rx: got %0d want 0", rxc[0]); end
    if (errc[0] !== 8'd0) begin n_bad++; $display("FAIL midreset_err: got %0d want 0", errc[0]); end
    if (tx_byte_s[0] !== 8'h00) begin n_bad++; $display("FAIL midreset_tx_byte: got %h want 00", tx_byte_s[0]); end
    if (tx_dv_s[0] !== 1'b0) begin n_bad++; $display("FAIL midreset_tx_dv: got %b want 0", tx_dv_s[0]); end
    hdr_model[0] = 1'b0;
    hdr_model[1] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    test_clean_run(0, "after_reset");
    test_clean_run(1, "seed_wrap");
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start[i]     = 1'b0;
      spur_dv[i]   = 1'b0;
      hdr_model[i] = 1'b0;
    end
    clear_faults();
    test_reset();
    test_clean_run(0, "first");
    test_clean_run(0, "second");
    test_corrupt();
    test_drop();
    test_random();
    test_ignored();
    test_done_boundary();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
